// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int AF_THRESH = 56,
    parameter int AE_THRESH = 8,
    parameter bit FWFT      = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              rd_ok;
    logic              wr_ok;

    // Handshake: write_en/read_en are requests; a request takes effect on the
    // edge where wr_ok/rd_ok is high. A full FIFO still takes a write when a
    // read is accepted on the same edge, so a simultaneous pair never overflows.
    assign rd_ok = read_en & ~fifo_empty;
    assign wr_ok = write_en & (~fifo_full | rd_ok);

    assign fifo_count   = count_q;
    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    // Storage is deliberately left out of reset; stale words are unreachable
    // once the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (rst && wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
            // A fresh error outranks a clear arriving on the same edge.
            if (write_en && !wr_ok) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (read_en && fifo_empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_out = mem[rd_ptr];
        end else begin : g_reg
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem[rd_ptr];
                end
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a registered-read instance checked against a
// reference model with an expected-data queue, plus a small FWFT instance.
module tb_sync_fifo_param;
    localparam int DEPTH = 64;

    logic       clk;
    logic       rst;
    logic       write_en;
    logic [7:0] data_in;
    logic       read_en;
    logic       err_clr;
    logic [7:0] data_out;
    logic       fifo_full;
    logic       fifo_empty;
    logic       almost_full;
    logic       almost_empty;
    logic [6:0] fifo_count;
    logic       overflow;
    logic       underflow;

    logic       f_write_en;
    logic [7:0] f_data_in;
    logic       f_read_en;
    logic       f_err_clr;
    logic [7:0] f_data_out;
    logic       f_full;
    logic       f_empty;
    logic       f_af;
    logic       f_ae;
    logic [6:0] f_count;
    logic       f_ovf;
    logic       f_unf;

    int checks = 0;
    int errors = 0;

    int         m_cnt;
    bit         m_ovf;
    bit         m_unf;
    logic [7:0] m_dout;
    logic [7:0] exp_q[$];

    sync_fifo_param #(.DATA_W(8), .ADDR_W(6), .AF_THRESH(56), .AE_THRESH(8), .FWFT(1'b0)) u_dut (
        .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in), .read_en(read_en),
        .err_clr(err_clr), .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .fifo_count(fifo_count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_W(8), .ADDR_W(6), .AF_THRESH(56), .AE_THRESH(8), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .write_en(f_write_en), .data_in(f_data_in), .read_en(f_read_en),
        .err_clr(f_err_clr), .data_out(f_data_out), .fifo_full(f_full), .fifo_empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .fifo_count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, " count"}, 32'(fifo_count), 32'(m_cnt));
        check({tag, " full"}, 32'(fifo_full), 32'(m_cnt == DEPTH));
        check({tag, " empty"}, 32'(fifo_empty), 32'(m_cnt == 0));
        check({tag, " almost_full"}, 32'(almost_full), 32'(m_cnt >= 56));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(m_cnt <= 8));
        check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, " underflow"}, 32'(underflow), 32'(m_unf));
        check({tag, " data_out"}, 32'(data_out), 32'(m_dout));
    endtask

    // One clock on the registered instance; the model decides acceptance from pre-edge state.
    task automatic step(input string tag, input logic we, input logic [7:0] din,
                        input logic re, input logic clr);
        bit rd_ok;
        bit wr_ok;
        rd_ok = re && (m_cnt != 0);
        wr_ok = we && ((m_cnt != DEPTH) || rd_ok);
        write_en = we;
        data_in  = din;
        read_en  = re;
        err_clr  = clr;
        @(posedge clk);
        if (re && m_cnt == 0) m_unf = 1'b1;
        else if (clr) m_unf = 1'b0;
        if (we && !wr_ok) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (rd_ok) m_dout = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(din);
        if (wr_ok && !rd_ok) m_cnt++;
        else if (rd_ok && !wr_ok) m_cnt--;
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
        err_clr  = 1'b0;
        check_status(tag);
    endtask

    // Reset for one edge with write_en held high; the write must be ignored.
    task automatic do_reset(input string tag);
        rst      = 1'b0;
        write_en = 1'b1;
        data_in  = 8'hC3;
        @(posedge clk);
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = 8'h00;
        exp_q.delete();
        @(negedge clk);
        rst      = 1'b1;
        write_en = 1'b0;
        check_status(tag);
    endtask

    task automatic fstep(input logic we, input logic [7:0] din, input logic re);
        f_write_en = we;
        f_data_in  = din;
        f_read_en  = re;
        @(posedge clk);
        @(negedge clk);
        f_write_en = 1'b0;
        f_read_en  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; write_en = 1'b0; data_in = '0; read_en = 1'b0; err_clr = 1'b0;
        f_write_en = 1'b0; f_data_in = '0; f_read_en = 1'b0; f_err_clr = 1'b0;
        m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dout = 8'h00;
        @(negedge clk);
        do_reset("reset");

        // Fill with 0..63; flags walk through almost_empty, almost_full and full.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);

        // Write into a full FIFO, hold, clear; then error and clear together.
        step("ovf_set", 1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("ovf_hold", 1'b0, 8'h00, 1'b0, 1'b0);
        step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        step("ovf_set_wins", 1'b1, 8'hEE, 1'b0, 1'b1);
        step("ovf_clr2", 1'b0, 8'h00, 1'b0, 1'b1);

        // Drain in order; extra reads underflow while data_out holds 63.
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        step("unf_set", 1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_hold_data", 32'(data_out), 32'h3F);
        step("unf_set_wins", 1'b0, 8'h00, 1'b1, 1'b1);
        step("unf_clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // Empty with write and read together: write taken, read rejected.
        step("empty_wr_rd", 1'b1, 8'h77, 1'b1, 1'b0);
        step("empty_wr_rd_pop", 1'b0, 8'h00, 1'b1, 1'b1);

        // Fill again, then stream through a full FIFO across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("full_wr_rd", 1'b1, 8'($urandom_range(1, 255)), 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // First-word-fall-through instance.
        check("fwft_reset_empty", 32'(f_empty), 32'h1);
        fstep(1'b1, 8'hA5, 1'b0);
        check("fwft_head", 32'(f_data_out), 32'hA5);
        check("fwft_not_empty", 32'(f_empty), 32'h0);
        fstep(1'b0, 8'h00, 1'b1);
        check("fwft_pop_empty", 32'(f_empty), 32'h1);
        check("fwft_pop_count", 32'(f_count), 32'h0);
        fstep(1'b1, 8'h11, 1'b0);
        fstep(1'b1, 8'h22, 1'b0);
        check("fwft_head2", 32'(f_data_out), 32'h11);
        fstep(1'b0, 8'h00, 1'b1);
        check("fwft_next_head", 32'(f_data_out), 32'h22);
        check("fwft_count1", 32'(f_count), 32'h1);
        fstep(1'b0, 8'h00, 1'b1);
        check("fwft_drained", 32'(f_empty), 32'h1);

        // Mid-operation reset discards stored words.
        for (int i = 0; i < 20; i++) step("pre_reset", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        check("pre_reset_data_nonzero", 32'(data_out != 8'h00), 32'h1);
        do_reset("mid_reset");
        step("post_reset_wr", 1'b1, 8'h5A, 1'b0, 1'b0);
        step("post_reset_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        check("post_reset_data", 32'(data_out), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
